regfile_writeback: RTL



---
 rtl/rv_pkg.sv | 16 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/regfile_writeback.sv | 99 +++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared types for the write-back path.
// Result entries and register address helpers.
package rv_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count-based full/empty.
// Push is refused when full, even with a same-cycle pop.
module sync_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage write; contents need no reset, the count guards them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back arbiter and long-latency scoreboard.
// ALU results win the single write port; queued results fill idle cycles.
module regfile_writeback #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [4:0]                alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      lq_valid,
    output logic                      lq_ready,
    input  logic [4:0]                lq_rd,
    input  logic [XLEN-1:0]           lq_data,
    input  logic                      mark_valid,
    input  logic [4:0]                mark_rd,
    output logic                      we3,
    output logic [4:0]                a3,
    output logic [XLEN-1:0]           wd3,
    output logic [31:0]               pending,
    output logic [$clog2(LQ_DEPTH):0] lq_count
);
    import rv_pkg::*;

    wb_entry_t       w_push_ent;
    wb_entry_t       w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [31:0]     w_set;
    logic [31:0]     w_clr;
    logic [31:0]     w_pend_nxt;

    logic            r_we3;
    reg_addr_t       r_a3;
    logic [XLEN-1:0] r_wd3;
    logic [31:0]     r_pending;

    assign w_push_ent.rd   = lq_rd;
    assign w_push_ent.data = lq_data;
    assign lq_ready        = !w_full;
    assign w_pop           = !alu_valid && !w_empty;

    sync_fifo #(
        .W     ($bits(wb_entry_t)),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (lq_valid),
        .i_data  (w_push_ent),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (lq_count)
    );

    assign w_set = (mark_valid && mark_rd != REG_ZERO)
                 ? (32'd1 << mark_rd) : 32'd0;
    assign w_clr = w_pop ? (32'd1 << w_head.rd) : 32'd0;
    // Set is applied after clear so a same-cycle set wins; x0 never pends.
    assign w_pend_nxt = ((r_pending & ~w_clr) | w_set) & ~32'd1;

    // Select ALU first, then queue head; register the write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we3 <= 1'b0;
            r_a3  <= REG_ZERO;
            r_wd3 <= '0;
        end else if (alu_valid) begin
            r_we3 <= (alu_rd != REG_ZERO);
            r_a3  <= alu_rd;
            r_wd3 <= alu_data;
        end else if (w_pop) begin
            r_we3 <= (w_head.rd != REG_ZERO);
            r_a3  <= w_head.rd;
            r_wd3 <= w_head.data;
        end else begin
            r_we3 <= 1'b0;
        end
    end

    // Scoreboard of destinations still awaiting a queued result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_nxt;
        end
    end

    assign we3     = r_we3;
    assign a3      = r_a3;
    assign wd3     = r_wd3;
    assign pending = r_pending;

endmodule
